dot_product_ctrl: RTL and testbench
===================================

# dot_product_ctrl

Sequencer that computes one dot product of two operand vectors on the shared MAC datapath. On `start` it clears the MAC, streams `len` operand pairs from two single-port operand memories (1-cycle read latency) into the MAC one pair per cycle, and waits out the MAC's two-stage multiply/accumulate pipeline. It then captures the accumulated value into `result` and pulses `done`. It sits between the command source (host/CSR layer) and the MAC plus operand memories.

## Interface
- `DATA_WIDTH`, 8: operand width; MAC accumulator and `result` are 3*DATA_WIDTH.
- `ADDR_WIDTH`, 8: operand memory address width.
- `clk` in 1: clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: command strobe; sampled only in IDLE.
- `len` in ADDR_WIDTH+1: number of element pairs; sampled with `start`.
- `base_a`, `base_b` in ADDR_WIDTH each: start addresses; sampled with `start`.
- `abort` in 1: cancel the current command.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `result` out 3*DATA_WIDTH: captured dot product, held until the next capture.
- `mem_rd_en` out 1: read strobe to both operand memories.
- `mem_addr_a`, `mem_addr_b` out ADDR_WIDTH each: read addresses.
- `mem_rdata_a`, `mem_rdata_b` in DATA_WIDTH each: read data, valid the cycle after `mem_rd_en`.
- `mac_clr` out 1: MAC clear.
- `mac_en` out 1: MAC enable.
- `mac_ain`, `mac_bin` out DATA_WIDTH each: MAC operands, combinational from `mem_rdata_a`/`mem_rdata_b`.
- `mac_cout` in 3*DATA_WIDTH: MAC accumulator.

## Operation
- FSM states: IDLE, CLR, FETCH, DRAIN, DONE.
- IDLE:
  - `start` with `len`≠0: latch inputs, go to CLR.
  - `start` with `len`=0: `result`←0, go to DONE; no memory or MAC activity.
- CLR: `mac_clr`=1 for one cycle, then go to FETCH.
- FETCH:
  - Issue reads k=0..len-1, one per cycle: `mem_addr_a`=base_a+k, `mem_addr_b`=base_b+k, both mod 2^ADDR_WIDTH (addresses wrap).
  - `mac_en` is the read strobe delayed one cycle.
  - After the last read, go to DRAIN.
- DRAIN: 3-cycle wait. This covers the final `mac_en` cycle plus the MAC's product register and accumulate register. On the last DRAIN edge, `result`←`mac_cout`, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored; no queuing.
- `abort` in any non-IDLE state:
  - Next cycle: `mac_clr`=1 and state IDLE.
  - No `done` pulse; `result` unchanged.
  - The pending read-data cycle does not assert `mac_en`.
  - `abort` takes priority over all transitions.
- Arithmetic: accumulation wraps mod 2^(3*DATA_WIDTH); no saturation. No overflow when ADDR_WIDTH ≤ DATA_WIDTH and `len` ≤ 2^ADDR_WIDTH.
- `len` up to 2^(ADDR_WIDTH+1)-1 is legal; addresses wrap and revisit elements.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE. `busy`, `done`, `result`, `mem_rd_en`, `mem_addr_a/b`, `mac_en`, `mac_clr` all 0. Reset mid-command discards the command without a `done` pulse.
- Cycle numbering, with `start` in cycle 0:
  - Cycle 1: CLR.
  - Cycles 2..len+1: reads.
  - Cycles 3..len+2: `mac_en`.
  - End of cycle len+4: capture.
  - Cycle len+5: `done`.
- `len`=0: `done` in cycle 1.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- The earliest new `start` is accepted in the cycle after `done`.
- `mac_clr` and `mac_en` are never high in the same cycle.

## Structure
- Package `dp_ctrl_pkg` holds:
  - FSM state enum.
  - `MEM_RD_LAT`=1, `MAC_LAT`=2; DRAIN length is derived from these.
- One sub-module, `dp_addr_cnt`: loadable element counter that produces the address offset k and a `last` flag.
- The MAC and operand memories stay outside this block.

## Test plan
- `len`=4, A=1,2,3,4, B=5,6,7,8 -> `result`=70; `done` in cycle 9; exactly 4 `mac_en` cycles (3..6).
- `len`=0 -> `done` in cycle 1, `result`=0, no `mem_rd_en` or `mac_en`.
- `base_a`=0xFE, `base_b`=0x10, `len`=4 -> `mem_addr_a` sequence FE, FF, 00, 01; `mem_addr_b` sequence 10..13.
- DATA_WIDTH=8, `len`=256, all operands 0xFF -> `result`=0xFE0100; `done` in cycle 261.
- `abort` in cycle 4 of a `len`=8 run:
  - Required: `mac_clr` in cycle 5, IDLE, no `done`, `result` unchanged.
  - Follow with `start` (`len`=2, A=3,3, B=2,2) -> `result`=12.
- Disturbances:
  - `start` pulses during `busy` -> ignored; the current result is unchanged.
  - `rst_n`=0 during FETCH -> all outputs 0 the next cycle; no `done`.

Source files
------------

// File: rtl/dp_ctrl_pkg.sv
// Shared definitions for the dot-product sequencer: FSM state encoding and
// the pipeline latencies that set the drain length.
package dp_ctrl_pkg;

    localparam int MEM_RD_LAT = 1;
    localparam int MAC_LAT    = 2;
    // One cycle for the last read to reach the MAC, then the MAC's own stages.
    localparam int DRAIN_LEN  = MEM_RD_LAT + MAC_LAT;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/dp_addr_cnt.sv
// Loadable element counter: restarts at zero on load, counts on inc, and
// flags the final element of the loaded limit.
module dp_addr_cnt #(
    parameter int CNT_WIDTH = 9,
    parameter int OFF_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 inc,
    input  logic [CNT_WIDTH-1:0] limit,
    output logic [OFF_WIDTH-1:0] offset,
    output logic                 last
);

    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] limit_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= '0;
            limit_q <= '0;
        end else if (load) begin
            count   <= '0;
            limit_q <= limit;
        end else if (inc) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    // Offsets wrap naturally; the full-width count still decides the end.
    assign offset = count[OFF_WIDTH-1:0];
    assign last   = (count == limit_q - CNT_WIDTH'(1));

endmodule

// File: rtl/dot_product_ctrl.sv
// Sequencer for one dot product on the shared MAC: clear, stream operand
// pairs from the two operand memories, drain the MAC pipeline, capture.
module dot_product_ctrl
    import dp_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH:0]     len,
    input  logic [ADDR_WIDTH-1:0]   base_a,
    input  logic [ADDR_WIDTH-1:0]   base_b,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [3*DATA_WIDTH-1:0] result,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr_a,
    output logic [ADDR_WIDTH-1:0]   mem_addr_b,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_a,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_b,
    output logic                    mac_clr,
    output logic                    mac_en,
    output logic [DATA_WIDTH-1:0]   mac_ain,
    output logic [DATA_WIDTH-1:0]   mac_bin,
    input  logic [3*DATA_WIDTH-1:0] mac_cout
);

    localparam int CNT_WIDTH = ADDR_WIDTH + 1;

    state_t                  state;
    state_t                  state_nx;
    logic [ADDR_WIDTH-1:0]   base_a_q;
    logic [ADDR_WIDTH-1:0]   base_b_q;
    logic                    abort_clr_q;
    logic                    mac_en_q;
    logic                    cnt_load;
    logic                    cnt_inc;
    logic [CNT_WIDTH-1:0]    cnt_limit;
    logic [ADDR_WIDTH-1:0]   offset;
    logic                    cnt_last;
    logic                    accept;
    logic                    kill;

    assign accept = (state == ST_IDLE) && start;
    assign kill   = (state != ST_IDLE) && abort;

    // The same counter walks the elements and then times the drain.
    assign cnt_load  = (accept && (len != '0)) || ((state == ST_FETCH) && cnt_last);
    assign cnt_inc   = (state == ST_FETCH) || (state == ST_DRAIN);
    assign cnt_limit = (state == ST_IDLE) ? len : CNT_WIDTH'(DRAIN_LEN);

    dp_addr_cnt #(
        .CNT_WIDTH (CNT_WIDTH),
        .OFF_WIDTH (ADDR_WIDTH)
    ) u_addr_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (cnt_load),
        .inc    (cnt_inc),
        .limit  (cnt_limit),
        .offset (offset),
        .last   (cnt_last)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = (len == '0) ? ST_DONE : ST_CLR;
            ST_CLR:   state_nx = ST_FETCH;
            ST_FETCH: if (cnt_last) state_nx = ST_DRAIN;
            ST_DRAIN: if (cnt_last) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        if (kill) state_nx = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            base_a_q    <= '0;
            base_b_q    <= '0;
            abort_clr_q <= 1'b0;
            mac_en_q    <= 1'b0;
            result      <= '0;
        end else begin
            state       <= state_nx;
            abort_clr_q <= kill;
            // The read in flight when an abort lands must not reach the MAC.
            mac_en_q    <= mem_rd_en && !abort;
            if (accept) begin
                base_a_q <= base_a;
                base_b_q <= base_b;
                if (len == '0) result <= '0;
            end
            if ((state == ST_DRAIN) && cnt_last && !abort) result <= mac_cout;
        end
    end

    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign mem_rd_en  = (state == ST_FETCH);
    assign mem_addr_a = mem_rd_en ? (base_a_q + offset) : '0;
    assign mem_addr_b = mem_rd_en ? (base_b_q + offset) : '0;
    assign mac_clr    = (state == ST_CLR) || abort_clr_q;
    assign mac_en     = mac_en_q;
    assign mac_ain    = mem_rdata_a;
    assign mac_bin    = mem_rdata_b;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Bench for dot_product_ctrl with behavioural operand memories and MAC around
// the DUT; expected results come from a plain sum over the memory arrays.
module tb_dot_product_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int RW = 3 * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic [AW-1:0] base_a = '0;
    logic [AW-1:0] base_b = '0;
    logic          abort = 1'b0;
    logic          busy;
    logic          done;
    logic [RW-1:0] result;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr_a;
    logic [AW-1:0] mem_addr_b;
    logic [DW-1:0] mem_rdata_a = '0;
    logic [DW-1:0] mem_rdata_b = '0;
    logic          mac_clr;
    logic          mac_en;
    logic [DW-1:0] mac_ain;
    logic [DW-1:0] mac_bin;
    logic [RW-1:0] mac_cout;

    always #5 clk = ~clk;

    dot_product_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .len         (len),
        .base_a      (base_a),
        .base_b      (base_b),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .mem_rd_en   (mem_rd_en),
        .mem_addr_a  (mem_addr_a),
        .mem_addr_b  (mem_addr_b),
        .mem_rdata_a (mem_rdata_a),
        .mem_rdata_b (mem_rdata_b),
        .mac_clr     (mac_clr),
        .mac_en      (mac_en),
        .mac_ain     (mac_ain),
        .mac_bin     (mac_bin),
        .mac_cout    (mac_cout)
    );

    // Operand memories with one cycle of read latency.
    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata_a <= mem_a[mem_addr_a];
            mem_rdata_b <= mem_b[mem_addr_b];
        end
    end

    // Two-stage MAC: product register, then accumulator.
    logic [2*DW-1:0] prod_q = '0;
    logic            prod_v = 1'b0;
    logic [RW-1:0]   acc_q = '0;
    assign mac_cout = acc_q;

    always @(posedge clk) begin
        if (mac_clr) begin
            prod_v <= 1'b0;
            acc_q  <= '0;
        end else begin
            prod_v <= mac_en;
            prod_q <= mac_ain * mac_bin;
            if (prod_v) acc_q <= acc_q + RW'(prod_q);
        end
    end

    int errors = 0;
    int checks = 0;

    // Scoreboard and per-run observations.
    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] exp_r;
    logic [RW-1:0] prev_result;
    int            done_cyc;
    logic [RW-1:0] done_result;
    int            en_cnt, en_first, en_last, rd_cnt, overlap, busy_bad;
    int            clr_cycles [$];
    logic [AW-1:0] addr_a_seen [$];
    logic [AW-1:0] addr_b_seen [$];

    function automatic logic [RW-1:0] ref_dot(input int n, input logic [AW-1:0] ba,
                                              input logic [AW-1:0] bb);
        logic [RW-1:0] acc = '0;
        for (int k = 0; k < n; k++)
            acc = acc + RW'(mem_a[(int'(ba) + k) % 256]) * RW'(mem_b[(int'(bb) + k) % 256]);
        return acc;
    endfunction

    function automatic int exp_done_cyc(input int n);
        return (n == 0) ? 1 : n + 5;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = DW'($urandom);
            mem_b[i] = DW'($urandom);
        end
    endtask

    // Issues one command in cycle 0 and observes cycles 1..max_cyc.
    task automatic run_cmd(input int n, input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                           input int abort_at, input bit noise, input int max_cyc,
                           input bit stop_at_done);
        logic exp_busy;
        done_cyc = -1; done_result = '0;
        en_cnt = 0; en_first = -1; en_last = -1; rd_cnt = 0; overlap = 0; busy_bad = 0;
        clr_cycles.delete(); addr_a_seen.delete(); addr_b_seen.delete();
        @(negedge clk);
        start = 1'b1; len = (AW+1)'(n); base_a = ba; base_b = bb;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            start = noise && (c >= 2) && (done_cyc < 0) && ($urandom_range(0, 2) == 0);
            if (noise) begin
                len = (AW+1)'($urandom); base_a = AW'($urandom); base_b = AW'($urandom);
            end
            abort = (c == abort_at);
            if (mem_rd_en) begin
                rd_cnt++;
                addr_a_seen.push_back(mem_addr_a);
                addr_b_seen.push_back(mem_addr_b);
            end
            if (mac_en) begin
                en_cnt++;
                if (en_first < 0) en_first = c;
                en_last = c;
            end
            if (mac_clr) clr_cycles.push_back(c);
            if (mac_clr && mac_en) overlap++;
            if (done && done_cyc < 0) begin
                done_cyc = c;
                done_result = result;
            end
            if (abort_at > 0) exp_busy = (c <= abort_at);
            else exp_busy = (done_cyc < 0) || (c == done_cyc);
            if (busy !== exp_busy) busy_bad++;
            if (stop_at_done && done_cyc > 0) break;
            if (abort_at < 0 && done_cyc > 0 && c >= done_cyc + 2) break;
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic check_run(input string name, input int n);
        checks++;
        if (done_cyc !== exp_done_cyc(n)) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_done_cyc(n));
        end
        exp_r = exp_q.pop_front();
        checks++;
        if (done_result !== exp_r) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, done_result, exp_r);
        end
        checks++;
        if (en_cnt !== n || rd_cnt !== n) begin
            errors++;
            $display("FAIL %s counts: mac_en=%0d rd_en=%0d expected %0d", name, en_cnt, rd_cnt, n);
        end
        checks++;
        if (busy_bad !== 0 || overlap !== 0) begin
            errors++;
            $display("FAIL %s busy/overlap: busy_bad=%0d overlap=%0d expected 0", name, busy_bad, overlap);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1; len = 9'd5; abort = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, done, mem_rd_en, mac_en, mac_clr} !== 5'b0 || result !== '0 ||
            mem_addr_a !== '0 || mem_addr_b !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b rd=%b en=%b clr=%b result=%h addr=%h/%h expected all 0",
                     busy, done, mem_rd_en, mac_en, mac_clr, result, mem_addr_a, mem_addr_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = DW'(i + 1);
            mem_b[i] = DW'(i + 5);
        end
        exp_q.push_back(RW'(70));
        run_cmd(4, 8'h00, 8'h00, -1, 1'b0, 30, 1'b0);
        check_run("basic", 4);
        checks++;
        if (en_first !== 3 || en_last !== 6) begin
            errors++;
            $display("FAIL basic mac_en_window: got %0d..%0d expected 3..6", en_first, en_last);
        end
        checks++;
        if (clr_cycles.size() !== 1 || clr_cycles[0] !== 1) begin
            errors++;
            $display("FAIL basic mac_clr: got %0d pulses, first %0d expected 1 pulse in cycle 1",
                     clr_cycles.size(), (clr_cycles.size() > 0) ? clr_cycles[0] : -1);
        end
    endtask

    task automatic test_zero_len();
        exp_q.push_back('0);
        run_cmd(0, 8'h33, 8'h44, -1, 1'b0, 20, 1'b0);
        check_run("zero_len", 0);
        checks++;
        if (clr_cycles.size() !== 0) begin
            errors++;
            $display("FAIL zero_len mac_clr: got %0d pulses expected 0", clr_cycles.size());
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea, eb;
        exp_q.push_back(ref_dot(4, 8'hFE, 8'h10));
        run_cmd(4, 8'hFE, 8'h10, -1, 1'b0, 30, 1'b0);
        check_run("wrap", 4);
        for (int k = 0; k < 4; k++) begin
            ea = AW'(254 + k);
            eb = AW'(16 + k);
            checks++;
            if (k >= addr_a_seen.size() || addr_a_seen[k] !== ea || addr_b_seen[k] !== eb) begin
                errors++;
                $display("FAIL wrap addr[%0d]: got %h/%h expected %h/%h", k,
                         (k < addr_a_seen.size()) ? addr_a_seen[k] : 8'hxx,
                         (k < addr_b_seen.size()) ? addr_b_seen[k] : 8'hxx, ea, eb);
            end
        end
    endtask

    task automatic test_full_len();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'hFF;
            mem_b[i] = 8'hFF;
        end
        exp_q.push_back(24'hFE0100);
        run_cmd(256, AW'($urandom), AW'($urandom), -1, 1'b0, 280, 1'b0);
        check_run("full_len", 256);
        fill_random();
    endtask

    task automatic test_random();
        int n;
        logic [AW-1:0] ba, bb;
        for (int t = 0; t < 6; t++) begin
            n = (t == 5) ? $urandom_range(257, 320) : $urandom_range(1, 40);
            ba = AW'($urandom);
            bb = AW'($urandom);
            exp_q.push_back(ref_dot(n, ba, bb));
            run_cmd(n, ba, bb, -1, 1'b0, n + 20, 1'b0);
            check_run("random", n);
        end
    endtask

    task automatic test_abort();
        prev_result = ref_dot(4, 8'hFE, 8'h10);
        exp_q.push_back(prev_result);
        run_cmd(4, 8'hFE, 8'h10, -1, 1'b0, 30, 1'b0);
        check_run("pre_abort", 4);
        run_cmd(8, 8'h20, 8'h40, 4, 1'b0, 25, 1'b0);
        checks++;
        if (done_cyc !== -1 || result !== prev_result) begin
            errors++;
            $display("FAIL abort hold: done_cycle=%0d result=%h expected no done and %h",
                     done_cyc, result, prev_result);
        end
        checks++;
        if (clr_cycles.size() !== 2 || clr_cycles[1] !== 5) begin
            errors++;
            $display("FAIL abort mac_clr: got %0d pulses, last %0d expected 2 pulses ending in cycle 5",
                     clr_cycles.size(), (clr_cycles.size() > 0) ? clr_cycles[clr_cycles.size()-1] : -1);
        end
        checks++;
        if (en_cnt !== 2 || busy_bad !== 0 || overlap !== 0) begin
            errors++;
            $display("FAIL abort activity: mac_en=%0d busy_bad=%0d overlap=%0d expected 2/0/0",
                     en_cnt, busy_bad, overlap);
        end
        mem_a[8'h60] = 8'd3; mem_a[8'h61] = 8'd3;
        mem_b[8'h70] = 8'd2; mem_b[8'h71] = 8'd2;
        exp_q.push_back(RW'(12));
        run_cmd(2, 8'h60, 8'h70, -1, 1'b0, 20, 1'b0);
        check_run("after_abort", 2);
    endtask

    task automatic test_start_ignored();
        int n;
        logic [AW-1:0] ba, bb;
        for (int t = 0; t < 2; t++) begin
            n = $urandom_range(3, 30);
            ba = AW'($urandom);
            bb = AW'($urandom);
            exp_q.push_back(ref_dot(n, ba, bb));
            run_cmd(n, ba, bb, -1, 1'b1, n + 20, 1'b0);
            check_run("start_ignored", n);
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2;
        logic [AW-1:0] ba, bb;
        n1 = $urandom_range(1, 12);
        n2 = $urandom_range(1, 12);
        ba = AW'($urandom);
        bb = AW'($urandom);
        exp_q.push_back(ref_dot(n1, ba, bb));
        run_cmd(n1, ba, bb, -1, 1'b0, n1 + 20, 1'b1);
        check_run("b2b_first", n1);
        exp_q.push_back(ref_dot(n2, bb, ba));
        run_cmd(n2, bb, ba, -1, 1'b0, n2 + 20, 1'b0);
        check_run("b2b_second", n2);
    endtask

    task automatic test_reset_mid();
        int late_done;
        @(negedge clk);
        start = 1'b1; len = 9'd20; base_a = 8'h05; base_b = 8'h09;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, mem_rd_en, mac_en, mac_clr} !== 5'b0 || result !== '0 ||
            mem_addr_a !== '0 || mem_addr_b !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs: busy=%b done=%b rd=%b en=%b clr=%b result=%h expected all 0",
                     busy, done, mem_rd_en, mac_en, mac_clr, result);
        end
        rst_n = 1'b1;
        late_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done || busy) late_done++;
        end
        checks++;
        if (late_done !== 0) begin
            errors++;
            $display("FAIL reset_mid discard: got %0d active cycles expected 0", late_done);
        end
        exp_q.push_back(ref_dot(7, 8'h80, 8'hC0));
        run_cmd(7, 8'h80, 8'hC0, -1, 1'b0, 30, 1'b0);
        check_run("after_reset", 7);
    endtask

    initial begin
        fill_random();
        test_reset();
        test_basic();
        test_zero_len();
        test_wrap();
        test_full_len();
        test_random();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
